spi_frame_master: RTL and testbench
===================================

// Module: spi_frame_master
// PURPOSE
//  SPI mode-0 master that serialises RGBW command frames (lint, red, green, blue, white,
//  colorIdx, mode) toward the lamp's SPI slave input (sck/mosi/cs). Used by the host-side
//  controller and by the self-test path. Bytes enter through a valid/ready stream; frames are
//  delimited by tx_last or by FRAME_BYTES. Drives sck/mosi/cs, MSB first, cs active low.
// PARAMETERS
//  CLK_DIV      2  clk cycles per sck half-period (>=1); one bit = 2*CLK_DIV clk cycles
//  FRAME_BYTES  7  max bytes per frame; frame is forced to end after this many bytes
//  CS_GAP       2  clk cycles cs is held high after a frame before the next may start
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-low reset
//  tx_data     in   8  byte to send
//  tx_valid    in   1  tx_data valid
//  tx_last     in   1  byte is last of frame (qualified by tx_valid)
//  tx_ready    out  1  holding register empty; byte accepted when tx_valid & tx_ready
//  sck         out  1  SPI clock, idle low
//  mosi        out  1  SPI data, changes on sck fall, stable at sck rise
//  cs          out  1  chip select, active low
//  busy        out  1  high from cs fall until end of CS_GAP
//  byte_cnt    out  4  bytes fully shifted in current frame
//  frame_done  out  1  one-cycle pulse when cs returns high
// BEHAVIOUR
//  - Reset (reset=0 at clk edge): sck=0, mosi=0, cs=1, tx_ready=1, busy=0, byte_cnt=0,
//    frame_done=0, holding register emptied, state IDLE. Mid-frame reset aborts the partial
//    byte; cs is high on the cycle after the reset edge. No frame_done for aborted frame.
//  - One-byte holding reg + 8-bit shifter. tx_ready = !hold_full; a byte may be accepted
//    in any state, including during shifting; last flag stored with byte.
//  - States: IDLE -> LOAD -> SHIFT -> (LOAD | STALL | END) ; STALL -> LOAD ; END -> GAP -> IDLE.
//  - IDLE: when hold_full, move to LOAD next cycle.
//  - LOAD (1 cycle): hold -> shifter, cs=0, mosi=bit7, busy=1; hold freed (tx_ready=1 next cycle).
//    Accept in IDLE at cycle T => cs low and mosi=MSB at T+2.
//  - SHIFT: sck low CLK_DIV cycles, then high CLK_DIV cycles per bit; on sck fall shifter
//    shifts left, mosi=next bit. After 8th high phase: sck=0, byte_cnt+1.
//  - Byte end: if byte flagged last or byte_cnt==FRAME_BYTES -> END. Else if hold_full ->
//    LOAD (gap of exactly one clk between bytes, cs stays low). Else STALL: cs low, sck low,
//    mosi holds, waits indefinitely for a byte.
//  - END: cs=1, frame_done=1 for 1 cycle, mosi=0. GAP: cs high CS_GAP cycles, busy=1;
//    then IDLE, busy=0, byte_cnt=0 (byte_cnt holds final count through GAP).
//  - Byte accepted during END/GAP waits in hold and starts the next frame from IDLE.
//  - Forced end at FRAME_BYTES ignores tx_last state; next byte starts a new frame.
//  - Half-period counter width = $clog2(CLK_DIV)+1; bit counter 3 bits, wraps 7->0 at byte end.
//  - All outputs registered; no combinational path from inputs to sck/mosi/cs.
// STRUCTURE
//  - Shared package rgbw_pkg: frame byte indices (IDX_LINT=0, IDX_RED=1, IDX_GREEN=2,
//    IDX_BLUE=3, IDX_WHITE=4, IDX_COLOR=5, IDX_MODE=6), RGBW_FRAME_BYTES=7, state encoding.
//  - Sub-module spi_clk_tick: half-period tick generator (enable, CLK_DIV), emits rise/fall
//    strobes; FSM, holding reg and shifter stay in spi_frame_master.
// TESTING (CLK_DIV=2, CS_GAP=2, FRAME_BYTES=7; SPI slave model samples on sck rise)
//  1 Single byte 0xA5 with tx_last, accepted at T -> cs low at T+2, 8 sck pulses (4 clk each),
//    slave gets 0xA5, frame_done pulse at T+2+32+1, busy low after GAP.
//  2 Back-to-back 7 bytes 0x80,0x11,0x22,0x33,0x44,0x05,0x01 held valid, tx_last on last ->
//    single cs-low window, 1 clk between bytes, byte_cnt=7, slave decodes all 7 in order.
//  3 8 bytes streamed, no tx_last -> cs rises after byte 7, frame_done, CS_GAP, 8th byte sent
//    in second frame with byte_cnt=1.
//  4 tx_valid drop after byte 2 for 50 cycles -> STALL: cs low, sck low 50 cycles, resumes,
//    no extra sck edges, slave data intact.
//  5 reset=0 during bit 4 of byte 3 -> next cycle cs=1, sck=0, tx_ready=1, byte_cnt=0, no
//    frame_done; new frame after reset transmits cleanly.
//  6 CLK_DIV=1 -> sck period 2 clk, 0xFF then 0x00 with tx_last: mosi stable on every rise.

Source files
------------

// File: rtl/rgbw_pkg.sv
// Shared RGBW lamp frame layout and SPI frame master state encoding.
package rgbw_pkg;

    localparam int IDX_LINT         = 0;
    localparam int IDX_RED          = 1;
    localparam int IDX_GREEN        = 2;
    localparam int IDX_BLUE         = 3;
    localparam int IDX_WHITE        = 4;
    localparam int IDX_COLOR        = 5;
    localparam int IDX_MODE         = 6;
    localparam int RGBW_FRAME_BYTES = 7;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_STALL = 3'd3;
    localparam logic [2:0] ST_END   = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

endpackage

// File: rtl/spi_clk_tick.sv
// SPI half-period tick generator: rise/fall strobes every CLK_DIV cycles while enabled.
// Latency: first rise strobe CLK_DIV cycles after enable goes high; phase restarts low when disabled.
// Backpressure: none; the strobes are advisory and the caller decides what to do with them.
module spi_clk_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt;
    logic          phase;
    logic          half_done;

    assign half_done = (cnt == CW'(CLK_DIV - 1));
    assign rise      = en && half_done && !phase;
    assign fall      = en && half_done && phase;

    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (half_done) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: byte stream in, MSB-first sck/mosi/cs (active low) out.
// Latency: byte accepted at edge T drives cs low with its MSB at T+2; 16*CLK_DIV+1 clk per byte.
// Backpressure: tx_ready drops while the one-byte holding register is full.
module spi_frame_master
    import rgbw_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int FRAME_BYTES = RGBW_FRAME_BYTES,
    parameter int CS_GAP      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       sck,
    output logic       mosi,
    output logic       cs,
    output logic       busy,
    output logic [3:0] byte_cnt,
    output logic       frame_done
);

    localparam int GW = $clog2(CS_GAP) + 1;

    logic [2:0]    state;
    logic [7:0]    hold_dat;
    logic          hold_last;
    logic          hold_full;
    logic [7:0]    shift_dat;
    logic          shift_last;
    logic [2:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          tick_rise;
    logic          tick_fall;

    assign tx_ready = ~hold_full;

    spi_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_SHIFT),
        .rise  (tick_rise),
        .fall  (tick_fall)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            hold_dat   <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            shift_dat  <= '0;
            shift_last <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            byte_cnt   <= '0;
            sck        <= 1'b0;
            mosi       <= 1'b0;
            cs         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (tx_valid && !hold_full) begin
                hold_dat  <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (hold_full) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_dat  <= hold_dat;
                    shift_last <= hold_last;
                    hold_full  <= 1'b0;
                    mosi       <= hold_dat[7];
                    cs         <= 1'b0;
                    busy       <= 1'b1;
                    bit_cnt    <= '0;
                    state      <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick_rise) sck <= 1'b1;
                    if (tick_fall) begin
                        sck     <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        // On the last fall mosi keeps bit 0 so a stall holds the line steady.
                        if (bit_cnt == 3'd7) begin
                            byte_cnt <= byte_cnt + 4'd1;
                            if (shift_last || byte_cnt == 4'(FRAME_BYTES - 1))
                                state <= ST_END;
                            else if (hold_full)
                                state <= ST_LOAD;
                            else
                                state <= ST_STALL;
                        end else begin
                            shift_dat <= {shift_dat[6:0], shift_dat[7]};
                            mosi      <= shift_dat[6];
                        end
                    end
                end
                ST_STALL: begin
                    if (hold_full) state <= ST_LOAD;
                end
                ST_END: begin
                    cs         <= 1'b1;
                    mosi       <= 1'b0;
                    frame_done <= 1'b1;
                    gap_cnt    <= '0;
                    state      <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(CS_GAP - 1)) begin
                        busy     <= 1'b0;
                        byte_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        gap_cnt  <= gap_cnt + GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboarded bench for spi_frame_master: a negedge SPI slave model per DUT pops expected bytes.
module tb_spi_frame_master;
    import rgbw_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data_a = '0, tx_data_b = '0;
    logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0;
    logic       tx_last_a = 1'b0, tx_last_b = 1'b0;
    logic       tx_ready_a, tx_ready_b, sck_a, sck_b, mosi_a, mosi_b, cs_a, cs_b;
    logic       busy_a, busy_b, frame_done_a, frame_done_b;
    logic [3:0] byte_cnt_a, byte_cnt_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [7:0] exp_q[$];
    int         exp_len[$];

    int         rx_cnt[2];
    int         sl_bits[2];
    int         rises[2];
    int         csfall_cyc[2];
    logic [7:0] sl_sr[2];
    logic       sck_q[2], mosi_q[2], cs_q[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_frame_master #(.CLK_DIV(2), .FRAME_BYTES(RGBW_FRAME_BYTES), .CS_GAP(2)) dut_a (
        .clk(clk), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_last(tx_last_a),
        .tx_ready(tx_ready_a), .sck(sck_a), .mosi(mosi_a), .cs(cs_a), .busy(busy_a),
        .byte_cnt(byte_cnt_a), .frame_done(frame_done_a));

    spi_frame_master #(.CLK_DIV(1), .FRAME_BYTES(RGBW_FRAME_BYTES), .CS_GAP(2)) dut_b (
        .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_last(tx_last_b),
        .tx_ready(tx_ready_b), .sck(sck_b), .mosi(mosi_b), .cs(cs_b), .busy(busy_b),
        .byte_cnt(byte_cnt_b), .frame_done(frame_done_b));

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model plus frame-level checks; runs on the falling clk edge, away from DUT updates.
    task automatic mon(input int k, input logic s, input logic m, input logic c,
                       input logic fd, input logic [3:0] bc);
        logic [7:0] e;
        int l;
        if (s && !sck_q[k]) rises[k]++;
        if (cs_q[k] && !c) begin
            rises[k] = 0;
            csfall_cyc[k] = cyc;
        end
        if (!reset || c) begin
            sl_bits[k] = 0;
        end else if (s && !sck_q[k]) begin
            chk("mosi_stable_at_rise", int'(m), int'(mosi_q[k]));
            sl_sr[k] = {sl_sr[k][6:0], m};
            sl_bits[k]++;
            if (sl_bits[k] == 8) begin
                sl_bits[k] = 0;
                rx_cnt[k]++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_byte dut%0d: got %0h expected none", k, sl_sr[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (sl_sr[k] !== e) begin
                        miscompares++;
                        $display("FAIL slave_byte dut%0d: got %0h expected %0h", k, sl_sr[k], e);
                    end
                end
            end
        end
        if (fd) begin
            vectors++;
            if (exp_len.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_frame_done dut%0d: got pulse expected none", k);
            end else begin
                l = exp_len.pop_front();
                chk("frame_byte_cnt", int'(bc), l);
                chk("frame_sck_rises", rises[k], 8 * l);
                chk("frame_done_cs_high", int'(c), 1);
            end
        end
        sck_q[k] = s;
        mosi_q[k] = m;
        cs_q[k] = c;
    endtask

    always @(negedge clk) begin
        mon(0, sck_a, mosi_a, cs_a, frame_done_a, byte_cnt_a);
        mon(1, sck_b, mosi_b, cs_b, frame_done_b, byte_cnt_b);
    end

    function automatic logic rdy(input int k);
        return (k == 0) ? tx_ready_a : tx_ready_b;
    endfunction

    function automatic logic fdone(input int k);
        return (k == 0) ? frame_done_a : frame_done_b;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with acc_cyc set.
    task automatic push(input int k, input logic [7:0] d, input logic last);
        int n = 0;
        exp_q.push_back(d);
        if (k == 0) begin
            tx_data_a = d; tx_last_a = last; tx_valid_a = 1'b1;
        end else begin
            tx_data_b = d; tx_last_b = last; tx_valid_b = 1'b1;
        end
        while (!rdy(k) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("push_accepted", int'(n < 400), 1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        tx_last_a = 1'b0;
        tx_last_b = 1'b0;
    endtask

    task automatic wait_fd(input int k, input int bound);
        int n = 0;
        while (!fdone(k) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_seen", int'(n < bound), 1);
    endtask

    task automatic wait_rx(input int k, input int target, input int bound);
        int n = 0;
        while (rx_cnt[k] < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("rx_progress", int'(n < bound), 1);
    endtask

    initial begin
        logic [7:0] frame[7];
        logic [7:0] strm[9];
        int t, n, base;

        for (int k = 0; k < 2; k++) begin
            rx_cnt[k] = 0; sl_bits[k] = 0; rises[k] = 0; csfall_cyc[k] = 0;
            sl_sr[k] = '0; sck_q[k] = 1'b0; mosi_q[k] = 1'b0; cs_q[k] = 1'b1;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", int'({sck_a, mosi_a, cs_a, tx_ready_a, busy_a, byte_cnt_a, frame_done_a}),
            int'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0}));
        chk("reset_outputs_b", int'({sck_b, mosi_b, cs_b, tx_ready_b, busy_b, byte_cnt_b, frame_done_b}),
            int'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0}));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte latency: cs low at T+2, frame_done at T+35, busy clears after gap
        exp_len.push_back(1);
        push(0, 8'hA5, 1'b1);
        t = acc_cyc;
        n = 0;
        while (cs_a && n < 20) begin @(negedge clk); n++; end
        chk("t1_cs_fall_latency", cyc - t, 2);
        chk("t1_first_mosi_msb", int'(mosi_a), 1);
        wait_fd(0, 100);
        chk("t1_frame_done_latency", cyc - t, 35);
        @(negedge clk);
        chk("t1_busy_in_gap", int'(busy_a), 1);
        @(negedge clk);
        chk("t1_busy_after_gap", int'({busy_a, byte_cnt_a}), 0);

        // 2: full RGBW frame back to back, one cs window of 7*33 clk
        frame[IDX_LINT] = 8'h80; frame[IDX_RED] = 8'h11; frame[IDX_GREEN] = 8'h22;
        frame[IDX_BLUE] = 8'h33; frame[IDX_WHITE] = 8'h44; frame[IDX_COLOR] = 8'h05;
        frame[IDX_MODE] = 8'h01;
        repeat (3) @(negedge clk);
        exp_len.push_back(7);
        for (int i = 0; i < 7; i++) push(0, frame[i], i == 6);
        wait_fd(0, 400);
        chk("t2_cs_window", cyc - csfall_cyc[0], 7 * 33);
        repeat (4) @(negedge clk);

        // 3: eight bytes, no tx_last: forced end after 7, 8th opens a second frame
        strm = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h81, 8'h3C};
        base = rx_cnt[0];
        exp_len.push_back(7);
        for (int i = 0; i < 8; i++) push(0, strm[i], 1'b0);
        wait_fd(0, 400);
        wait_rx(0, base + 8, 200);
        repeat (10) @(negedge clk);
        chk("t3_second_frame_cnt", int'(byte_cnt_a), 1);
        chk("t3_second_frame_cs", int'(cs_a), 0);
        exp_len.push_back(2);
        push(0, strm[8], 1'b1);
        wait_fd(0, 200);
        repeat (4) @(negedge clk);

        // 4: stall mid frame, cs held low and sck idle
        base = rx_cnt[0];
        exp_len.push_back(4);
        push(0, 8'hDE, 1'b0);
        push(0, 8'hAD, 1'b0);
        wait_rx(0, base + 2, 200);
        repeat (10) @(negedge clk);
        chk("t4_stall_cs_sck", int'({cs_a, sck_a, tx_ready_a}), int'({1'b0, 1'b0, 1'b1}));
        repeat (40) @(negedge clk);
        chk("t4_stall_still", int'({cs_a, sck_a, busy_a}), int'({1'b0, 1'b0, 1'b1}));
        push(0, 8'hBE, 1'b0);
        push(0, 8'hEF, 1'b1);
        wait_fd(0, 300);
        repeat (4) @(negedge clk);

        // 5: reset during byte 3 with a fourth byte waiting in the holding register
        base = rx_cnt[0];
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b0);
        push(0, 8'h44, 1'b0);
        wait_rx(0, base + 2, 200);
        n = 0;
        while (sl_bits[0] < 4 && n < 100) begin @(negedge clk); n++; end
        chk("t5_reached_bit4", int'(n < 100), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_after_reset", int'({cs_a, sck_a, tx_ready_a, busy_a, byte_cnt_a}),
            int'({1'b1, 1'b0, 1'b1, 1'b0, 4'd0}));
        reset = 1'b1;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        repeat (10) @(negedge clk);
        chk("t5_idle_after_reset", int'({cs_a, busy_a}), int'({1'b1, 1'b0}));
        exp_len.push_back(2);
        push(0, 8'h5A, 1'b0);
        push(0, 8'hC3, 1'b1);
        wait_fd(0, 200);
        repeat (4) @(negedge clk);

        // 6: CLK_DIV=1, 0xFF then 0x00
        exp_len.push_back(2);
        push(1, 8'hFF, 1'b0);
        push(1, 8'h00, 1'b1);
        wait_fd(1, 200);
        chk("t6_cs_window", cyc - csfall_cyc[1], 2 * 17);
        repeat (4) @(negedge clk);

        chk("exp_bytes_drained", exp_q.size(), 0);
        chk("exp_frames_drained", exp_len.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
